// File: rtl/inning_scoreboard_if.sv
// Pulse inputs and game-status outputs of the inning scoreboard.
// master drives the pulses (upstream logic / bench); slave is the scoreboard.
interface inning_scoreboard_if;
   logic       change_pulse;
   logic [3:0] run_pulse;
   logic       team;
   logic [7:0] inning_bcd;
   logic [7:0] score0_bcd;
   logic [7:0] score1_bcd;
   logic       in_play;
   logic [1:0] winner;

   modport master (
      output change_pulse, run_pulse,
      input  team, inning_bcd, score0_bcd, score1_bcd, in_play, winner
   );

   modport slave (
      input  change_pulse, run_pulse,
      output team, inning_bcd, score0_bcd, score1_bcd, in_play, winner
   );
endinterface

// File: rtl/inning_scoreboard.sv
// Game-level scoreboard: batting team, BCD inning and scores, walk-off and game end.
// Optional extra innings are enabled by defining EXTRA_INNINGS_EN.
module inning_scoreboard #(
   parameter int NUM_INNINGS = 9,
   parameter int MAX_INNINGS = 15
) (
   input logic                clk_divided,
   input logic                reset_n,
   inning_scoreboard_if.slave bus
);

   typedef enum logic [1:0] {TOP, BOTTOM, OVER} state_t;

   localparam logic [7:0] NUM_BCD = 8'(((NUM_INNINGS / 10) << 4) | (NUM_INNINGS % 10));
   localparam logic [7:0] MAX_BCD = 8'(((MAX_INNINGS / 10) << 4) | (MAX_INNINGS % 10));

   state_t     state;
   logic       team;
   logic       in_play;
   logic [1:0] winner;
   logic [7:0] inning;
   logic [7:0] score0;
   logic [7:0] score1;

   logic [2:0] runs;
   logic [7:0] new_score0;
   logic [7:0] new_score1;
   logic [7:0] next_inning;
   logic       late;

   // Runs are at most 4, so a single decimal carry out of the ones digit is enough.
   function automatic logic [7:0] bcd_add(input logic [7:0] value, input logic [2:0] n);
      logic [4:0] ones;
      logic [3:0] tens;
      ones = {1'b0, value[3:0]} + {2'b00, n};
      tens = value[7:4];
      if (ones > 5'd9) begin
         ones = ones - 5'd10;
         tens = tens + 4'd1;
      end
      if (tens > 4'd9) return 8'h99;
      return {tens, ones[3:0]};
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] value);
      logic [3:0] ones;
      logic [3:0] tens;
      ones = value[3:0];
      tens = value[7:4];
      if (ones == 4'd9) begin
         ones = 4'd0;
         tens = tens + 4'd1;
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

   // BCD values order the same way as their binary encodings, so plain compares work.
   always_comb begin
      runs        = 3'(bus.run_pulse[0]) + 3'(bus.run_pulse[1])
                  + 3'(bus.run_pulse[2]) + 3'(bus.run_pulse[3]);
      new_score0  = (state == TOP)    ? bcd_add(score0, runs) : score0;
      new_score1  = (state == BOTTOM) ? bcd_add(score1, runs) : score1;
      next_inning = (inning < MAX_BCD) ? bcd_inc(inning) : inning;
      late        = (inning >= NUM_BCD);
   end

   always_ff @(posedge clk_divided or negedge reset_n) begin
      if (!reset_n) begin
         state   <= TOP;
         team    <= 1'b0;
         in_play <= 1'b1;
         winner  <= 2'b00;
         inning  <= 8'h01;
         score0  <= 8'h00;
         score1  <= 8'h00;
      end else begin
         case (state)
            TOP: begin
               score0 <= new_score0;
               if (bus.change_pulse) begin
                  if (late && (score1 > new_score0)) begin
                     state   <= OVER;
                     winner  <= 2'b10;
                     in_play <= 1'b0;
                  end else begin
                     state <= BOTTOM;
                     team  <= 1'b1;
                  end
               end
            end
            BOTTOM: begin
               score1 <= new_score1;
               // A walk-off ends the game before any same-edge change pulse is considered.
               if (late && (new_score1 > score0)) begin
                  state   <= OVER;
                  winner  <= 2'b10;
                  in_play <= 1'b0;
               end else if (bus.change_pulse) begin
                  if (!late) begin
                     inning <= next_inning;
                     state  <= TOP;
                     team   <= 1'b0;
                  end else if (score0 > new_score1) begin
                     state   <= OVER;
                     winner  <= 2'b01;
                     in_play <= 1'b0;
                  end
`ifdef EXTRA_INNINGS_EN
                  else if (inning < MAX_BCD) begin
                     inning <= next_inning;
                     state  <= TOP;
                     team   <= 1'b0;
                  end
`endif
                  else begin
                     state   <= OVER;
                     winner  <= 2'b11;
                     in_play <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.team       = team;
   assign bus.inning_bcd = inning;
   assign bus.score0_bcd = score0;
   assign bus.score1_bcd = score1;
   assign bus.in_play    = in_play;
   assign bus.winner     = winner;

endmodule

// File: tb/tb_inning_scoreboard.sv
// Directed self-checking bench for inning_scoreboard with hand-computed expectations.
// Covers scoring, BCD saturation, inning sequencing, walk-off, skipped bottom and async reset.
module tb_inning_scoreboard;

   logic clk_divided;
   logic reset_n;
   int   vectors;
   int   miscompares;

   inning_scoreboard_if bus ();

   inning_scoreboard #(.NUM_INNINGS(9), .MAX_INNINGS(15)) dut (
      .clk_divided (clk_divided),
      .reset_n     (reset_n),
      .bus         (bus)
   );

   initial clk_divided = 1'b0;
   always #5 clk_divided = ~clk_divided;

   // Drives one cycle of pulses starting at a falling edge; returns on the next falling edge.
   task automatic applyStimulus(input logic change, input logic [3:0] runs);
      @(negedge clk_divided);
      bus.change_pulse = change;
      bus.run_pulse    = runs;
      @(negedge clk_divided);
      bus.change_pulse = 1'b0;
      bus.run_pulse    = 4'b0000;
   endtask

   task automatic checkOutput(input string tag, input logic exp_team, input logic [7:0] exp_inning,
                              input logic [7:0] exp_s0, input logic [7:0] exp_s1,
                              input logic exp_in_play, input logic [1:0] exp_winner);
      vectors++;
      assert ({bus.team, bus.inning_bcd, bus.score0_bcd, bus.score1_bcd, bus.in_play, bus.winner}
              === {exp_team, exp_inning, exp_s0, exp_s1, exp_in_play, exp_winner})
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed team=%b inning=%h s0=%h s1=%h in_play=%b winner=%b, expected team=%b inning=%h s0=%h s1=%h in_play=%b winner=%b",
                tag, bus.team, bus.inning_bcd, bus.score0_bcd, bus.score1_bcd, bus.in_play, bus.winner,
                exp_team, exp_inning, exp_s0, exp_s1, exp_in_play, exp_winner);
      end
   endtask

   task automatic doReset();
      @(negedge clk_divided);
      reset_n = 1'b0;
      @(negedge clk_divided);
      reset_n = 1'b1;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      reset_n          = 1'b0;
      bus.change_pulse = 1'b0;
      bus.run_pulse    = 4'b0000;
      repeat (2) @(negedge clk_divided);
      checkOutput("reset", 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 2'b00);
      reset_n = 1'b1;

      // Four runners home in the top half
      applyStimulus(1'b0, 4'b1111);
      checkOutput("four_runs", 1'b0, 8'h01, 8'h04, 8'h00, 1'b1, 2'b00);

      // Decimal carry, then saturation at 99
      repeat (2) applyStimulus(1'b0, 4'b1111);
      checkOutput("bcd_carry_12", 1'b0, 8'h01, 8'h12, 8'h00, 1'b1, 2'b00);
      repeat (21) applyStimulus(1'b0, 4'b1111);
      applyStimulus(1'b0, 4'b0001);
      checkOutput("score_97", 1'b0, 8'h01, 8'h97, 8'h00, 1'b1, 2'b00);
      applyStimulus(1'b0, 4'b0111);
      checkOutput("saturate_99", 1'b0, 8'h01, 8'h99, 8'h00, 1'b1, 2'b00);
      applyStimulus(1'b0, 4'b0001);
      checkOutput("hold_99", 1'b0, 8'h01, 8'h99, 8'h00, 1'b1, 2'b00);

      // Scoreless innings 1..8, then a tied ninth
      doReset();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 4'b0000);
         checkOutput("to_bottom", 1'b1, 8'(i), 8'h00, 8'h00, 1'b1, 2'b00);
         applyStimulus(1'b1, 4'b0000);
         checkOutput("to_top", 1'b0, 8'(i + 1), 8'h00, 8'h00, 1'b1, 2'b00);
      end
      applyStimulus(1'b1, 4'b0000);
      checkOutput("ninth_bottom", 1'b1, 8'h09, 8'h00, 8'h00, 1'b1, 2'b00);
      applyStimulus(1'b1, 4'b0000);
`ifdef EXTRA_INNINGS_EN
      checkOutput("extra_inning", 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 2'b00);
`else
      checkOutput("tie_over", 1'b1, 8'h09, 8'h00, 8'h00, 1'b0, 2'b11);
      applyStimulus(1'b1, 4'b1111);
      checkOutput("tie_hold", 1'b1, 8'h09, 8'h00, 8'h00, 1'b0, 2'b11);
`endif

      // Walk-off in the ninth with a change pulse on the same edge
      doReset();
      applyStimulus(1'b0, 4'b0111);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0011);
      applyStimulus(1'b1, 4'b0000);
      repeat (14) applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b1, 4'b0000);
      checkOutput("walkoff_setup", 1'b1, 8'h09, 8'h03, 8'h02, 1'b1, 2'b00);
      applyStimulus(1'b1, 4'b0011);
      checkOutput("walkoff", 1'b1, 8'h09, 8'h03, 8'h04, 1'b0, 2'b10);

      // Home leads after the top of the ninth: bottom half skipped
      doReset();
      applyStimulus(1'b0, 4'b0001);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b1111);
      applyStimulus(1'b0, 4'b1000);
      applyStimulus(1'b1, 4'b0000);
      repeat (14) applyStimulus(1'b1, 4'b0000);
      checkOutput("skip_setup", 1'b0, 8'h09, 8'h01, 8'h05, 1'b1, 2'b00);
      applyStimulus(1'b1, 4'b0000);
      checkOutput("skip_bottom", 1'b0, 8'h09, 8'h01, 8'h05, 1'b0, 2'b10);
      applyStimulus(1'b1, 4'b1111);
      checkOutput("over_hold", 1'b0, 8'h09, 8'h01, 8'h05, 1'b0, 2'b10);

      // Visitor wins; run and change together credit the visitor first
      doReset();
      repeat (16) applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b1, 4'b0100);
      checkOutput("run_with_change", 1'b1, 8'h09, 8'h01, 8'h00, 1'b1, 2'b00);
      applyStimulus(1'b1, 4'b0000);
      checkOutput("visitor_wins", 1'b1, 8'h09, 8'h01, 8'h00, 1'b0, 2'b01);

      // Asynchronous reset mid-game
      doReset();
      applyStimulus(1'b0, 4'b0011);
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0111);
      applyStimulus(1'b1, 4'b0000);
      repeat (4) applyStimulus(1'b1, 4'b0000);
      checkOutput("inning4", 1'b0, 8'h04, 8'h02, 8'h03, 1'b1, 2'b00);
      @(posedge clk_divided);
      #2 reset_n = 1'b0;
      #1 checkOutput("async_reset", 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 2'b00);
      @(negedge clk_divided);
      reset_n = 1'b1;
      applyStimulus(1'b0, 4'b0001);
      checkOutput("after_release", 1'b0, 8'h01, 8'h01, 8'h00, 1'b1, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
